tap_ctrl_p: RTL and testbench

Parametrised IEEE 1149.1 TAP controller. It is the successor to the 4-bit `fsm` block and adds three things: the full 16-state TMS-driven state machine, an instruction register of width IR_W, and built-in BYPASS and IDCODE data registers. It sits between the JTAG pins and the user data-register chain. It exports state, decoded IR and DR strobes for external test data registers.

---
 rtl/tap_pkg.sv | 45 ++++
 rtl/tap_fsm.sv | 52 +++++
 rtl/tap_ctrl_p.sv | 146 ++++++++++++++
 tb/tb_tap_ctrl_p.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tap_pkg
// Purpose  : Shared types and constants for the tap_ctrl_p JTAG TAP controller.
//            Holds the 16-state TAP encoding, the IR capture pattern and the
//            IDCODE register width.
// Contents : tap_state_t   - 4-bit TAP state encoding (IEEE 1149.1 values)
//            c_IR_CAPTURE  - pattern loaded into the IR shift register in CAP_IR
//            c_IDCODE_W    - IDCODE data register width
//            is_shift()    - true in SH_DR / SH_IR
// Revision : 1.0 - initial release
// ============================================================================
package tap_pkg;

   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PA_DR  = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PA_IR  = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_t;

   // The two LSBs captured into the IR are fixed at 2'b01 by 1149.1 so that a
   // broken scan chain can be detected from the first shifted bits.
   localparam logic [1:0] c_IR_CAPTURE = 2'b01;

   localparam int c_IDCODE_W = 32;

   function automatic logic is_shift(input tap_state_t s);
      return (s == SH_DR) || (s == SH_IR);
   endfunction

endpackage : tap_pkg
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tap_fsm
// Purpose  : IEEE 1149.1 TAP state register and TMS-driven next-state logic.
// Ports    : CLK    in  test clock (TCK), rising edge
//            RST_N  in  asynchronous active-low reset (TRST*), forces TLR
//            ENABLE in  clock enable; low holds the state
//            TMS    in  mode select
//            STATE  out current TAP state (registered)
// Revision : 1.0 - initial release
// ============================================================================
module tap_fsm
   import tap_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ENABLE,
   input  logic       TMS,
   output tap_state_t STATE
);

   tap_state_t r_state;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= TLR;
      end else if (ENABLE) begin
         case (r_state)
            TLR    : r_state <= TMS ? TLR    : RTI;
            RTI    : r_state <= TMS ? SEL_DR : RTI;
            SEL_DR : r_state <= TMS ? SEL_IR : CAP_DR;
            CAP_DR : r_state <= TMS ? EX1_DR : SH_DR;
            SH_DR  : r_state <= TMS ? EX1_DR : SH_DR;
            EX1_DR : r_state <= TMS ? UPD_DR : PA_DR;
            PA_DR  : r_state <= TMS ? EX2_DR : PA_DR;
            EX2_DR : r_state <= TMS ? UPD_DR : SH_DR;
            UPD_DR : r_state <= TMS ? SEL_DR : RTI;
            SEL_IR : r_state <= TMS ? TLR    : CAP_IR;
            CAP_IR : r_state <= TMS ? EX1_IR : SH_IR;
            SH_IR  : r_state <= TMS ? EX1_IR : SH_IR;
            EX1_IR : r_state <= TMS ? UPD_IR : PA_IR;
            PA_IR  : r_state <= TMS ? EX2_IR : PA_IR;
            EX2_IR : r_state <= TMS ? UPD_IR : SH_IR;
            UPD_IR : r_state <= TMS ? SEL_DR : RTI;
         endcase
      end
   end

   assign STATE = r_state;

endmodule : tap_fsm
`default_nettype wire

// File: rtl/tap_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : tap_ctrl_p
// Purpose  : Parametrised IEEE 1149.1 TAP controller. Contains the TAP state
//            machine (tap_fsm), an IR_W-bit instruction register, a 1-bit
//            BYPASS register and, optionally, a 32-bit IDCODE register.
//            Decoded strobes let external test data registers hook in.
// Macro    : TAP_IDCODE_EN - when defined, the IDCODE register exists and the
//            IR resets to IDCODE_OPC; otherwise the IR resets to BYPASS_OPC
//            and IDCODE_OPC selects the external DR like any other opcode.
// Params   : IR_W (>=2), BYPASS_OPC, IDCODE_OPC, IDCODE_VAL (bit 0 = 1)
// Ports    : CLK, RST_N           TCK and asynchronous active-low TRST*
//            ENABLE               clock enable; low holds every register
//            TMS, TDI             JTAG inputs
//            TDO, TDO_EN          serial output and its enable (SH_DR/SH_IR)
//            STATE                current TAP state
//            IR                   current instruction
//            CAPTURE_DR/SHIFT_DR/UPDATE_DR  DR-state strobes
//            EXT_SEL              external DR selected by the IR
//            EXT_TDO              serial output of the external DR
// Revision : 1.0 - initial release
// ============================================================================
module tap_ctrl_p
   import tap_pkg::*;
#(
   parameter int                IR_W       = 4,
   parameter logic [IR_W-1:0]   BYPASS_OPC = '1,
   parameter logic [IR_W-1:0]   IDCODE_OPC = IR_W'(1),
   parameter logic [31:0]       IDCODE_VAL = 32'h0ABC_D0E1
)(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ENABLE,
   input  logic              TMS,
   input  logic              TDI,
   output logic              TDO,
   output logic              TDO_EN,
   output logic [3:0]        STATE,
   output logic [IR_W-1:0]   IR,
   output logic              CAPTURE_DR,
   output logic              SHIFT_DR,
   output logic              UPDATE_DR,
   output logic              EXT_SEL,
   input  logic              EXT_TDO
);

`ifdef TAP_IDCODE_EN
   localparam logic            c_ID_EN  = 1'b1;
   localparam logic [IR_W-1:0] c_IR_RST = IDCODE_OPC;
`else
   localparam logic            c_ID_EN  = 1'b0;
   localparam logic [IR_W-1:0] c_IR_RST = BYPASS_OPC;
`endif

   tap_state_t        w_state;
   logic [IR_W-1:0]   r_ir;
   logic [IR_W-1:0]   r_ir_sr;
   logic              r_bypass;
   logic              w_sel_byp;
   logic              w_sel_id;
   logic              w_id_lsb;

   tap_fsm u_fsm (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .ENABLE (ENABLE),
      .TMS    (TMS),
      .STATE  (w_state)
   );

   assign w_sel_byp = (r_ir == BYPASS_OPC);
   assign w_sel_id  = c_ID_EN && (r_ir == IDCODE_OPC) && !w_sel_byp;

   // ------------------------------------------------------------------------
   // Instruction register and bypass register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ir     <= c_IR_RST;
         r_ir_sr  <= '0;
         r_bypass <= 1'b0;
      end else if (ENABLE) begin
         case (w_state)
            CAP_IR : r_ir_sr <= IR_W'(c_IR_CAPTURE);
            SH_IR  : r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};
            UPD_IR : r_ir    <= r_ir_sr;
            // TLR is only entered from TLR itself or from SEL_IR with TMS=1,
            // so reloading on those edges makes IR valid on the first TLR cycle.
            SEL_IR : if (TMS) r_ir <= c_IR_RST;
            TLR    : r_ir <= c_IR_RST;
            CAP_DR : if (w_sel_byp) r_bypass <= 1'b0;
            SH_DR  : if (w_sel_byp) r_bypass <= TDI;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // IDCODE register
   // ------------------------------------------------------------------------
`ifdef TAP_IDCODE_EN
   logic [c_IDCODE_W-1:0] r_idcode;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_idcode <= '0;
      end else if (ENABLE && w_sel_id) begin
         if (w_state == CAP_DR) begin
            r_idcode <= IDCODE_VAL;
         end else if (w_state == SH_DR) begin
            r_idcode <= {TDI, r_idcode[c_IDCODE_W-1:1]};
         end
      end
   end

   assign w_id_lsb = r_idcode[0];
`else
   // No IDCODE register in this build; w_sel_id is constant 0 so this value
   // never reaches TDO.
   assign w_id_lsb = IDCODE_VAL[0];
`endif

   // ------------------------------------------------------------------------
   // Outputs: all Moore decodes of the registered state
   // ------------------------------------------------------------------------
   always_comb begin
      TDO = 1'b0;
      if (w_state == SH_IR) begin
         TDO = r_ir_sr[0];
      end else if (w_state == SH_DR) begin
         if (w_sel_byp)     TDO = r_bypass;
         else if (w_sel_id) TDO = w_id_lsb;
         else               TDO = EXT_TDO;
      end
   end

   assign TDO_EN     = is_shift(w_state);
   assign STATE      = w_state;
   assign IR         = r_ir;
   assign CAPTURE_DR = (w_state == CAP_DR);
   assign SHIFT_DR   = (w_state == SH_DR);
   assign UPDATE_DR  = (w_state == UPD_DR);
   assign EXT_SEL    = !w_sel_byp && !w_sel_id;

endmodule : tap_ctrl_p
`default_nettype wire

// File: tb/tb_tap_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_ctrl_p
// Purpose  : Scoreboard testbench for tap_ctrl_p. A driver issues TMS/TDI/
//            ENABLE stimulus and pushes expected outputs computed by a
//            queue-based reference model; a monitor on the falling edge pops
//            and compares. Honours TAP_IDCODE_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_ctrl_p;

   localparam int          IR_W  = 4;
   localparam logic [3:0]  BYP   = 4'hF;
   localparam logic [3:0]  IDOPC = 4'h1;
   localparam logic [31:0] IDV   = 32'h0ABC_D0E1;
`ifdef TAP_IDCODE_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif
   localparam logic [3:0] IR_RST = FEAT ? IDOPC : BYP;

   // State encodings
   localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6,
                          S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PA_DR = 4'h3, S_EX2_DR = 4'h0,
                          S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA,
                          S_EX1_IR = 4'h9, S_PA_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;

   logic            CLK = 1'b0;
   logic            RST_N, ENABLE, TMS, TDI, EXT_TDO;
   logic            TDO, TDO_EN, CAPTURE_DR, SHIFT_DR, UPDATE_DR, EXT_SEL;
   logic [3:0]      STATE;
   logic [IR_W-1:0] IR;

   tap_ctrl_p #(
      .IR_W       (IR_W),
      .BYPASS_OPC (BYP),
      .IDCODE_OPC (IDOPC),
      .IDCODE_VAL (IDV)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .ENABLE     (ENABLE),
      .TMS        (TMS),
      .TDI        (TDI),
      .TDO        (TDO),
      .TDO_EN     (TDO_EN),
      .STATE      (STATE),
      .IR         (IR),
      .CAPTURE_DR (CAPTURE_DR),
      .SHIFT_DR   (SHIFT_DR),
      .UPDATE_DR  (UPDATE_DR),
      .EXT_SEL    (EXT_SEL),
      .EXT_TDO    (EXT_TDO)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] ir;
      logic       ext, en, cap, sh, upd;
   } exp_t;

   exp_t st_q[$];
   bit   exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_on  = 1'b0;

   // Reference model: TAP transition table plus one queue of bits standing for
   // whichever shift register is currently being scanned (front = TDO side).
   logic [3:0] nxt0 [16];
   logic [3:0] nxt1 [16];
   logic [3:0] m_state;
   logic [3:0] m_ir;
   bit         m_sr[$];
   bit         m_rst;
   logic [31:0] idv_v;

   task automatic add_row(logic [3:0] s, logic [3:0] n0, logic [3:0] n1);
      nxt0[s] = n0;
      nxt1[s] = n1;
   endtask

   task automatic init_tbl();
      add_row(S_TLR,    S_RTI,    S_TLR);
      add_row(S_RTI,    S_RTI,    S_SEL_DR);
      add_row(S_SEL_DR, S_CAP_DR, S_SEL_IR);
      add_row(S_CAP_DR, S_SH_DR,  S_EX1_DR);
      add_row(S_SH_DR,  S_SH_DR,  S_EX1_DR);
      add_row(S_EX1_DR, S_PA_DR,  S_UPD_DR);
      add_row(S_PA_DR,  S_PA_DR,  S_EX2_DR);
      add_row(S_EX2_DR, S_SH_DR,  S_UPD_DR);
      add_row(S_UPD_DR, S_RTI,    S_SEL_DR);
      add_row(S_SEL_IR, S_CAP_IR, S_TLR);
      add_row(S_CAP_IR, S_SH_IR,  S_EX1_IR);
      add_row(S_SH_IR,  S_SH_IR,  S_EX1_IR);
      add_row(S_EX1_IR, S_PA_IR,  S_UPD_IR);
      add_row(S_PA_IR,  S_PA_IR,  S_EX2_IR);
      add_row(S_EX2_IR, S_SH_IR,  S_UPD_IR);
      add_row(S_UPD_IR, S_RTI,    S_SEL_DR);
   endtask

   // 0 = bypass, 1 = idcode, 2 = external
   function automatic int sel_of(logic [3:0] ir);
      if (ir == BYP)          return 0;
      if (FEAT && ir == IDOPC) return 1;
      return 2;
   endfunction

   function automatic bit rbit();
      return ($urandom_range(0, 1) == 1);
   endfunction

   task automatic fail_msg(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      if (act !== req) fail_msg(name, act, req);
      else             n_tests++;
   endtask

   task automatic model_reset();
      m_rst   = 1'b1;
      m_state = S_TLR;
      m_ir    = IR_RST;
      m_sr.delete();
   endtask

   task automatic model_edge(bit tms, bit tdi, bit en);
      logic [3:0] nx;
      if (m_rst || !en) return;
      nx = tms ? nxt1[m_state] : nxt0[m_state];
      case (m_state)
         S_CAP_IR: begin
            m_sr.delete();
            for (int i = 0; i < IR_W; i++) m_sr.push_back(i == 0);
         end
         S_SH_IR: begin
            void'(m_sr.pop_front());
            m_sr.push_back(tdi);
         end
         S_UPD_IR: begin
            m_ir = '0;
            for (int i = 0; i < IR_W; i++) m_ir[i] = m_sr[i];
         end
         S_CAP_DR: begin
            m_sr.delete();
            if (sel_of(m_ir) == 0) m_sr.push_back(1'b0);
            else if (sel_of(m_ir) == 1)
               for (int i = 0; i < 32; i++) m_sr.push_back(idv_v[i]);
         end
         S_SH_DR: begin
            if (sel_of(m_ir) != 2) begin
               void'(m_sr.pop_front());
               m_sr.push_back(tdi);
            end
         end
         default: ;
      endcase
      if (nx == S_TLR) m_ir = IR_RST;
      m_state = nx;
   endtask

   task automatic push_expect();
      exp_t e;
      e.st  = m_state;
      e.ir  = m_ir;
      e.ext = (sel_of(m_ir) == 2);
      e.en  = (m_state == S_SH_DR) || (m_state == S_SH_IR);
      e.cap = (m_state == S_CAP_DR);
      e.sh  = (m_state == S_SH_DR);
      e.upd = (m_state == S_UPD_DR);
      st_q.push_back(e);
      if (m_state == S_SH_IR)
         exp_q.push_back(m_sr[0]);
      else if (m_state == S_SH_DR)
         exp_q.push_back((sel_of(m_ir) == 2) ? EXT_TDO : m_sr[0]);
   endtask

   // Called just after a rising edge; ends just after the next rising edge.
   task automatic step(bit tms, bit tdi, bit en);
      TMS     = tms;
      TDI     = tdi;
      ENABLE  = en;
      EXT_TDO = rbit();
      push_expect();
      @(posedge CLK);
      model_edge(tms, tdi, en);
      #1;
   endtask

   // Asserts reset in the middle of a cycle and holds it for 'cycles' edges.
   task automatic do_reset(int cycles);
      #2;
      RST_N = 1'b0;
      model_reset();
      #1;
      check("rst_state_async", 32'(STATE), 32'(S_TLR));
      check("rst_tdo_en", 32'(TDO_EN), 32'd0);
      check("rst_ir", 32'(IR), 32'(IR_RST));
      repeat (cycles) begin
         TMS    = rbit();
         TDI    = rbit();
         ENABLE = 1'b1;
         push_expect();
         @(posedge CLK);
         #1;
      end
      RST_N = 1'b1;
      m_rst = 1'b0;
   endtask

   task automatic to_rti();
      repeat (5) step(1'b1, rbit(), 1'b1);
      step(1'b0, rbit(), 1'b1);
   endtask

   task automatic ir_scan(logic [3:0] v);
      step(1, 0, 1); step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
      for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, v[i], 1);
      step(1, 0, 1); step(0, 0, 1);
   endtask

   task automatic dr_scan(int n, logic [31:0] data);
      step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
      for (int i = 0; i < n; i++) step(i == n - 1, data[i], 1);
      step(1, 0, 1); step(0, 0, 1);
   endtask

   // Monitor: state/IR/strobes every cycle, TDO whenever TDO_EN is presented.
   exp_t e_mon;
   always @(negedge CLK) begin
      if (mon_on) begin
         if (st_q.size() == 0) begin
            fail_msg("st_q_underflow", 32'(STATE), 32'hFFFF_FFFF);
         end else begin
            e_mon = st_q.pop_front();
            check("state", 32'(STATE), 32'(e_mon.st));
            check("ir", 32'(IR), 32'(e_mon.ir));
            check("flags{ext,en,cap,sh,upd}",
                  32'({EXT_SEL, TDO_EN, CAPTURE_DR, SHIFT_DR, UPDATE_DR}),
                  32'({e_mon.ext, e_mon.en, e_mon.cap, e_mon.sh, e_mon.upd}));
         end
         if (TDO_EN) begin
            if (exp_q.size() == 0) fail_msg("tdo_q_underflow", 32'(TDO), 32'hFFFF_FFFF);
            else                   check("tdo", 32'(TDO), 32'(exp_q.pop_front()));
         end else begin
            check("tdo_idle", 32'(TDO), 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      init_tbl();
      idv_v   = IDV;
      RST_N   = 1'b0;
      ENABLE  = 1'b0;
      TMS     = 1'b1;
      TDI     = 1'b0;
      EXT_TDO = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      mon_on = 1'b1;
      do_reset(2);

      // IDCODE (or bypass when the feature is off) straight after reset
      step(0, 0, 1);
      dr_scan(32, $urandom());

      // Five TMS=1 from SH_DR with a disabled cycle in the middle
      step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
      step(1, 0, 1); step(1, 0, 1); step(1, 0, 0);
      step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
      step(0, 0, 1);

      // IR scan of all ones selects BYPASS, then the 8-bit bypass pattern
      ir_scan(4'hF);
      dr_scan(8, 32'h0000_00B3);

      // Explicit IDCODE opcode
      ir_scan(IDOPC);
      dr_scan(32, $urandom());

      // External DR, reset in the middle of the shift
      ir_scan(4'h5);
      step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
      repeat (6) step(0, rbit(), 1);
      do_reset(2);
      to_rti();

      // Randomised traffic with occasional resets
      for (int k = 0; k < 800; k++) begin
         if (k % 200 == 199) do_reset(1);
         else step($urandom_range(0, 99) < 30, rbit(), $urandom_range(0, 9) != 0);
      end
      to_rti();

      check("st_q_drain", 32'(st_q.size()), 32'd0);
      check("tdo_q_drain", 32'(exp_q.size()), 32'd0);
      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_tap_ctrl_p
`default_nettype wire
